// File: rtl/speech_seq.sv
// speech_seq: phoneme sequencer feeding the flash playback FSM.
// Queues phoneme codes, resolves each through an external registered lookup
// table and hands the resulting byte range to the playback FSM on each
// pico_flag / pico_done handshake.
// Optional feature: define SPEECH_SEQ_GAP_EN to insert a silent gap segment
// after every spoken phoneme.
module speech_seq #(
  parameter int          DEPTH     = 16,
  parameter int          CODE_W    = 6,
  parameter logic [23:0] GAP_START = 24'h0,
  parameter logic [23:0] GAP_END   = 24'h3FC
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CODE_W-1:0]          code_in,
  input  logic                       code_wr,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [CODE_W-1:0]          tbl_code,
  input  logic [23:0]                tbl_start,
  input  logic [23:0]                tbl_end,
  input  logic                       pico_flag,
  output logic                       pico_done,
  output logic [23:0]                start_address,
  output logic [23:0]                end_address,
  output logic                       silent,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    WAIT_END,
    FETCH,
    LOOKUP,
    LOAD,
    ACK
`ifdef SPEECH_SEQ_GAP_EN
    , GAP
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [23:0]        start_q, start_d, end_q, end_d;
  logic               silent_q, silent_d;
  logic               push, pop, empty, full;
`ifdef SPEECH_SEQ_GAP_EN
  logic               gap_q, gap_d;
`endif

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // Next-state, datapath loads and FIFO pointer/occupancy update
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    start_d  = start_q;
    end_d    = end_q;
    silent_d = silent_q;
    pop      = 1'b0;
`ifdef SPEECH_SEQ_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      WAIT_END: begin
        if (pico_flag) begin
`ifdef SPEECH_SEQ_GAP_EN
          if (gap_q) begin
            state_d = GAP;
          end else
`endif
          if (empty) begin
            silent_d = 1'b1;
            state_d  = ACK;
          end else begin
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        if (!empty) begin
          pop    = 1'b1;
          code_d = mem_q[rd_q];
        end
        state_d = LOOKUP;
      end
      LOOKUP: state_d = LOAD;
      LOAD: begin
        if (tbl_end >= tbl_start) begin
          start_d  = tbl_start;
          end_d    = tbl_end;
          silent_d = 1'b0;
`ifdef SPEECH_SEQ_GAP_EN
          gap_d    = 1'b1;
`endif
        end else begin
          silent_d = 1'b1;
        end
        state_d = ACK;
      end
`ifdef SPEECH_SEQ_GAP_EN
      GAP: begin
        start_d  = GAP_START;
        end_d    = GAP_END;
        silent_d = 1'b1;
        gap_d    = 1'b0;
        state_d  = ACK;
      end
`endif
      ACK: begin
        if (!pico_flag) state_d = WAIT_END;
      end
      default: state_d = WAIT_END;
    endcase

    // A pop in the same cycle frees the slot, so a write while full is kept
    push = code_wr && (!full || pop);
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= WAIT_END;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      code_q   <= '0;
      start_q  <= '0;
      end_q    <= '0;
      silent_q <= 1'b1;
`ifdef SPEECH_SEQ_GAP_EN
      gap_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      start_q  <= start_d;
      end_q    <= end_d;
      silent_q <= silent_d;
`ifdef SPEECH_SEQ_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clock) begin
    if (reset && push) mem_q[wr_q] <= code_in;
  end

  assign fifo_full     = full;
  assign fifo_count    = cnt_q;
  assign tbl_code      = code_q;
  assign start_address = start_q;
  assign end_address   = end_q;
  assign silent        = silent_q;
  assign pico_done     = (state_q == ACK);
  assign busy          = !((state_q == WAIT_END) && empty);

endmodule

// File: tb/tb_speech_seq.sv
// Self-checking bench for speech_seq: transaction-level model of the queue
// and of each playback handshake, with a registered lookup table model.
module tb_speech_seq;

  localparam int          DEPTH  = 16;
  localparam int          CODE_W = 6;
  localparam logic [23:0] GAP_S  = 24'h0;
  localparam logic [23:0] GAP_E  = 24'h3FC;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [CODE_W-1:0] code_in = '0;
  logic              code_wr = 1'b0;
  logic              fifo_full;
  logic [4:0]        fifo_count;
  logic [CODE_W-1:0] tbl_code;
  logic [23:0]       tbl_start = '0, tbl_end = '0;
  logic              pico_flag = 1'b0;
  logic              pico_done;
  logic [23:0]       start_address, end_address;
  logic              silent, busy;

  speech_seq #(.DEPTH(DEPTH), .CODE_W(CODE_W), .GAP_START(GAP_S), .GAP_END(GAP_E)) dut (
    .clock(clock), .reset(reset), .code_in(code_in), .code_wr(code_wr),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .tbl_code(tbl_code),
    .tbl_start(tbl_start), .tbl_end(tbl_end), .pico_flag(pico_flag),
    .pico_done(pico_done), .start_address(start_address), .end_address(end_address),
    .silent(silent), .busy(busy)
  );

  always #5 clock = ~clock;

  // External registered lookup table
  logic [23:0] tbl_s [64];
  logic [23:0] tbl_e [64];
  always @(posedge clock) begin
    tbl_start <= tbl_s[tbl_code];
    tbl_end   <= tbl_e[tbl_code];
  end

  // Reference model state
  logic [CODE_W-1:0] q[$];
  logic [23:0]       m_start, m_end;
  logic              m_silent;
  bit                m_gap;
`ifdef SPEECH_SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_start  = '0;
    m_end    = '0;
    m_silent = 1'b1;
    m_gap    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pico_flag = 1'b0;
    code_wr = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_count"},  32'(fifo_count), 32'(0));
    check({tag, "_full"},   32'(fifo_full), 32'(0));
    check({tag, "_start"},  32'(start_address), 32'(0));
    check({tag, "_end"},    32'(end_address), 32'(0));
    check({tag, "_code"},   32'(tbl_code), 32'(0));
    check({tag, "_silent"}, 32'(silent), 32'(1));
    check({tag, "_done"},   32'(pico_done), 32'(0));
    check({tag, "_busy"},   32'(busy), 32'(0));
  endtask

  // Enqueue one code while the sequencer is idle
  task automatic write_code(input logic [CODE_W-1:0] c);
    code_in = c;
    code_wr = 1'b1;
    step();
    code_wr = 1'b0;
    if (q.size() < DEPTH) q.push_back(c);
    check("wr_count", 32'(fifo_count), 32'(q.size()));
    check("wr_full",  32'(fifo_full), 32'(q.size() == DEPTH));
  endtask

  // One pico_flag/pico_done handshake; optionally writes a code during FETCH
  task automatic handshake(input bit wr_req, input logic [CODE_W-1:0] wc);
    int kind;               // 0 empty, 1 fetch, 2 gap
    int exp_lat;
    int n;
    bit wr;
    logic [CODE_W-1:0] code;
    code = '0;
    if (m_gap) begin
      kind = 2; exp_lat = 2;
      m_start = GAP_S; m_end = GAP_E; m_silent = 1'b1; m_gap = 1'b0;
    end else if (q.size() == 0) begin
      kind = 0; exp_lat = 1;
      m_silent = 1'b1;
    end else begin
      kind = 1; exp_lat = 4;
      code = q.pop_front();
      if (tbl_e[code] >= tbl_s[code]) begin
        m_start = tbl_s[code]; m_end = tbl_e[code]; m_silent = 1'b0;
        m_gap = GAP_ON;
      end else begin
        m_silent = 1'b1;
      end
    end
    wr = wr_req && (kind == 1);
    if (wr) q.push_back(wc);

    pico_flag = 1'b1;
    n = 0;
    while (n < 10) begin
      step();
      n++;
      if (wr && n == 1) begin
        code_in = wc;
        code_wr = 1'b1;
      end
      if (wr && n == 2) code_wr = 1'b0;
      if (pico_done) break;
    end
    code_wr = 1'b0;
    check("hs_latency", 32'(n), 32'(exp_lat));
    check("hs_start",   32'(start_address), 32'(m_start));
    check("hs_end",     32'(end_address), 32'(m_end));
    check("hs_silent",  32'(silent), 32'(m_silent));
    check("hs_busy",    32'(busy), 32'(1));
    check("hs_count",   32'(fifo_count), 32'(q.size()));
    if (kind == 1) check("hs_tbl_code", 32'(tbl_code), 32'(code));
    repeat ($urandom_range(0, 1)) begin
      step();
      check("hs_done_hold", 32'(pico_done), 32'(1));
    end
    pico_flag = 1'b0;
    step();
    check("hs_done_fall", 32'(pico_done), 32'(0));
    check("hs_idle_busy", 32'(busy), 32'(q.size() != 0));
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() != 0 || m_gap) && guard < 3 * DEPTH + 4) begin
      handshake(1'b0, '0);
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      tbl_s[i] = ($urandom & 24'hFFF000) | 24'h001000;
      tbl_e[i] = tbl_s[i] + 24'({$urandom_range(0, 1023), 2'b00});
      if (i % 7 == 5) tbl_e[i] = tbl_s[i] - 24'd4;
    end
    tbl_s[3] = 24'h001000; tbl_e[3] = 24'h0013FC;
    tbl_s[7] = 24'h002000; tbl_e[7] = 24'h0027FC;
    tbl_s[9] = 24'h001000; tbl_e[9] = 24'h000FFC;

    reset = 1'b0;
    step();
    step();
    do_reset();
    check_idle_outputs("reset");

    // Empty queue handshake: silent loop of the old range
    handshake(1'b0, '0);

    // Codes 3 and 7, then any trailing gap
    write_code(6'd3);
    write_code(6'd7);
    drain();

    // Invalid table entry keeps addresses, goes silent
    write_code(6'd9);
    drain();

    // Overfill, then write during FETCH while full
    for (int i = 0; i < DEPTH + 1; i++) write_code(6'($urandom));
    check("full_flag", 32'(fifo_full), 32'(1));
    handshake(1'b1, 6'd42);
    check("full_after_pop_push", 32'(fifo_count), 32'(DEPTH));
    drain();

    // Reset while LOOKUP is in flight
    write_code(6'd3);
    write_code(6'd7);
    pico_flag = 1'b1;
    step();
    step();
    reset = 1'b0;
    pico_flag = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
    check_idle_outputs("rst_lookup");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) write_code(6'($urandom));
      handshake(($urandom % 3) == 0, 6'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
